// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO: register-array storage, occupancy count,
// programmable almost-full/almost-empty thresholds and registered error pulses.
module sync_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_en,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_en,
    output logic [WIDTH-1:0] r_data,
    output logic             r_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] AfLevel = CW'(AF_LEVEL);
    localparam logic [AW:0] AeLevel = CW'(AE_LEVEL);
    localparam logic [AW:0] Depth   = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] r_data_q;
    logic             r_valid_q, overflow_q, underflow_q;
    logic             wa, ra;

    // Flags decode only registered state, so no input reaches an output combinationally.
    assign full         = (count_q == Depth);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfLevel);
    assign almost_empty = (count_q <= AeLevel);
    assign count        = count_q;
    assign r_data       = r_data_q;
    assign r_valid      = r_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is allowed when a read frees the oldest slot the same cycle.
    assign wa = w_en && (!full || r_en);
    assign ra = r_en && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({wa, ra})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately unreset; old-data-on-collision falls out of NBA ordering.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wp_q] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            r_valid_q   <= ra;
            overflow_q  <= w_en && !wa;
            underflow_q <= r_en && !ra;
            if (wa) begin
                wp_q <= wp_q + 1'b1;
            end
            if (ra) begin
                rp_q     <= rp_q + 1'b1;
                r_data_q <= mem[rp_q];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo at WIDTH=8, DEPTH=16.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       r_en = 1'b0;
    logic [7:0] r_data;
    logic       r_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_en         (w_en),
        .w_data       (w_data),
        .r_en         (r_en),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " count"}, 32'(count), 0);
        chk({tag, " empty"}, 32'(empty), 1);
        chk({tag, " almost_empty"}, 32'(almost_empty), 1);
        chk({tag, " full"}, 32'(full), 0);
        chk({tag, " almost_full"}, 32'(almost_full), 0);
        chk({tag, " r_valid"}, 32'(r_valid), 0);
        chk({tag, " r_data"}, 32'(r_data), 0);
        chk({tag, " overflow"}, 32'(overflow), 0);
        chk({tag, " underflow"}, 32'(underflow), 0);
    endtask

    initial begin
        // Reset, then idle for 10 cycles.
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_reset_outputs("idle");
        end

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1;
            w_data = 8'(i);
            step();
            chk("fill count", 32'(count), 32'(i + 1));
            chk("fill full", 32'(full), 32'(i == 15));
            chk("fill almost_full", 32'(almost_full), 32'(i + 1 >= 14));
            chk("fill almost_empty", 32'(almost_empty), 32'(i + 1 <= 2));
            chk("fill empty", 32'(empty), 0);
        end

        // Write into full FIFO alone: rejected.
        w_data = 8'hA5;
        step();
        chk("ovf pulse", 32'(overflow), 1);
        chk("ovf count", 32'(count), 16);
        w_en = 1'b0;
        step();
        chk("ovf clears", 32'(overflow), 0);

        // Drain 16 words; 0xA5 must not appear.
        r_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain r_data", 32'(r_data), 32'(i));
            chk("drain r_valid", 32'(r_valid), 1);
            chk("drain count", 32'(count), 32'(15 - i));
            chk("drain almost_empty", 32'(almost_empty), 32'(15 - i <= 2));
        end
        chk("drain empty", 32'(empty), 1);

        // Read while empty: underflow, no valid, data held.
        step();
        chk("udf pulse", 32'(underflow), 1);
        chk("udf r_valid", 32'(r_valid), 0);
        chk("udf r_data held", 32'(r_data), 32'h0F);
        r_en = 1'b0;
        step();
        chk("udf clears", 32'(underflow), 0);
        chk("idle r_valid", 32'(r_valid), 0);

        // Refill, then simultaneous write+read while full.
        w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_data = 8'(i);
            step();
        end
        chk("refill full", 32'(full), 1);
        w_data = 8'hA5;
        r_en = 1'b1;
        step();
        chk("full wr+rd r_data", 32'(r_data), 32'h00);
        chk("full wr+rd r_valid", 32'(r_valid), 1);
        chk("full wr+rd count", 32'(count), 16);
        chk("full wr+rd overflow", 32'(overflow), 0);
        w_en = 1'b0;
        for (int i = 1; i < 17; i++) begin
            step();
            chk("wrap r_data", 32'(r_data), (i == 16) ? 32'hA5 : 32'(i));
            chk("wrap count", 32'(count), 32'(16 - i));
        end
        chk("wrap empty", 32'(empty), 1);

        // Simultaneous write+read while empty: no fall-through.
        w_en = 1'b1;
        w_data = 8'h3C;
        step();
        chk("empty wr+rd underflow", 32'(underflow), 1);
        chk("empty wr+rd count", 32'(count), 1);
        chk("empty wr+rd r_valid", 32'(r_valid), 0);
        w_en = 1'b0;
        step();
        chk("follow-up r_data", 32'(r_data), 32'h3C);
        chk("follow-up r_valid", 32'(r_valid), 1);
        chk("follow-up count", 32'(count), 0);
        r_en = 1'b0;
        step();

        // Asynchronous reset in the middle of a 10-word burst.
        w_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_data = 8'(8'h80 + i);
            step();
        end
        chk("burst count", 32'(count), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async rst");
        step();
        step();
        chk("rst ignores w_en", 32'(count), 0);
        w_en = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk_reset_outputs("post rst");
        w_en = 1'b1;
        w_data = 8'h5A;
        step();
        chk("post rst wr count", 32'(count), 1);
        w_en = 1'b0;
        r_en = 1'b1;
        step();
        chk("post rst r_data", 32'(r_data), 32'h5A);
        chk("post rst r_valid", 32'(r_valid), 1);
        chk("post rst count", 32'(count), 0);
        r_en = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO built on the team's dual-port register-array memory, generalising the 16x8 fixed memory into a WIDTH x DEPTH buffer with internal pointer management, occupancy count, programmable almost-full/almost-empty thresholds and error pulses. It sits between a producer and a consumer in the same clock domain. Typical uses are UART RX/TX staging and sample buffering on the iCE40 board designs.

## Interface
- WIDTH, 8: data word width in bits (1..32).
- DEPTH, 16: number of entries; must be a power of two, 2..256.
- AW, $clog2(DEPTH): pointer width; derived, not overridden.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- w_en  in  1  write request.
- w_data  in  WIDTH  write data, sampled with w_en.
- r_en  in  1  read request.
- r_data  out  WIDTH  registered read data.
- r_valid  out  1  high for exactly one cycle when r_data holds a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

## Operation
- Storage: DEPTH x WIDTH register array, no reset on contents; write pointer wp and read pointer rp are AW bits each and wrap DEPTH-1 -> 0 by natural overflow.
- Write accepted (wa) when w_en && (!full || r_en): mem[wp] <= w_data, wp <= wp+1.
- Read accepted (ra) when r_en && !empty: r_data <= mem[rp], rp <= rp+1, r_valid <= 1. Otherwise r_valid <= 0 and r_data holds its previous value.
- Full with w_en and r_en: both accepted; count stays DEPTH; the read returns the oldest word, never the word being written.
- Empty with w_en and r_en: write accepted, read rejected (no fall-through); underflow pulses; count becomes 1.
- Count update: +1 on wa only, -1 on ra only, unchanged on both or neither.
- overflow <= w_en && !wa; underflow <= r_en && !ra; both are registered, so they appear in the cycle after the offending request.
- Flags full, empty, almost_full, almost_empty are decoded from the registered count. They change only at the edge that updates count.
- Reset (rst_n low, any time, including mid-burst): wp=rp=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, r_data=0, r_valid=0, overflow=0, underflow=0. Memory contents are undefined afterwards. Requests are ignored while rst_n is low. Operation resumes on the first rising edge with rst_n high.

## Timing
- Write latency: a word written at edge k is counted at edge k; empty deasserts after edge k. A read issued in the cycle after edge k is accepted at edge k+1, with r_data/r_valid valid after edge k+1.
- Read latency: 1 cycle from the accepting edge to r_data, matching the existing memory's registered read.
- Sustained throughput: one write and one read per cycle, at any occupancy 1..DEPTH.
- No combinational path exists from w_en/r_en to any output.

## Test plan
- Reset then idle: count=0, empty=1, almost_empty=1, full=0, r_valid=0, r_data=0x00 for 10 cycles.
- Write 0x00..0x0F (DEPTH=16), then read 16 times: r_data = 0x00..0x0F in order, with r_valid high on each read. full=1 after the 16th write, almost_full=1 at count 14, empty=1 after the last read.
- When full, write 0xA5 alone -> overflow pulses once, count stays 16, and the subsequent reads contain no 0xA5. When empty, read alone -> underflow pulses and r_valid stays 0.
- When full, w_en+r_en with 0xA5 -> r_data=0x00 and count=16. Drain the FIFO: the last word is 0xA5, confirming pointer wrap.
- When empty, w_en+r_en with 0x3C -> underflow=1 and count=1; next-cycle read returns 0x3C.
- Assert rst_n low mid-way through a 10-word burst (async, not edge-aligned) -> all outputs take reset values immediately; after release, write/read 0x5A returns 0x5A with count back to 0.
